// File: rtl/beta_ctrl_pkg.sv
// Shared encodings for the Beta CPU run/step/halt sequencer:
// host command opcodes, controller states and stop reasons.
package beta_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_RUN       = 3'd1,
    OP_HALT      = 3'd2,
    OP_STEP      = 3'd3,
    OP_SET_BP    = 3'd4,
    OP_CLR_BP    = 3'd5,
    OP_CPU_RESET = 3'd6,
    OP_CLR_CNT   = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } ctrl_state_e;

  typedef enum logic [2:0] {
    SR_NONE        = 3'd0,
    SR_HOST        = 3'd1,
    SR_HALT_INSTR  = 3'd2,
    SR_BREAKPOINT  = 3'd3,
    SR_STEP        = 3'd4,
    SR_WATCHDOG    = 3'd5
  } stop_reason_e;

endpackage

// File: rtl/run_stat_counter.sv
// Free-running statistics counter: wraps silently, and a clear beats a
// simultaneous increment.
module run_stat_counter
  import beta_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [WORD_W-1:0] count_o
);

  logic [WORD_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + WORD_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the Beta CPU core: owns the core reset and
// runCPU enable, takes host commands, and records why the core stopped.
module cpu_run_ctrl
  import beta_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int AUTO_RUN     = 0,
  parameter int WDT_CYCLES   = 0
) (
  input  logic              clk,
  input  logic              reset,
  // Host port: a command is taken on any edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on state, and unaccepted commands are dropped.
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [WORD_W-1:0] cmd_data,
  output logic              cmd_ready,
  input  logic              cpu_retire,
  input  logic [WORD_W-1:0] cpu_pc,
  input  logic              cpu_halt_instr,
  output logic              cpu_reset,
  output logic              run_cpu,
  output logic [1:0]        ctrl_state,
  output logic [2:0]        stop_reason,
  output logic              stopped,
  output logic [WORD_W-1:0] cycle_count,
  output logic [WORD_W-1:0] instr_count
);

  localparam logic [31:0] BOOT_RELOAD = 32'(RESET_CYCLES);
  localparam logic [31:0] WDT_LIMIT   = 32'(WDT_CYCLES);

  ctrl_state_e       state_q;
  stop_reason_e      stop_reason_q;
  stop_reason_e      stop_d;
  cmd_op_e           op;
  logic [31:0]       boot_cnt_q;
  logic [31:0]       wdt_q;
  logic [31:0]       wdt_next;
  logic [WORD_W-1:0] bp_addr_q;
  logic              bp_en_q;
  logic              first_q;
  logic              stopped_q;
  logic              cmd_fire;
  logic              in_session;
  logic              retire;
  logic              clr_cnt;

  always_comb begin
    op         = cmd_op_e'(cmd_op);
    cmd_fire   = cmd_valid && (state_q != ST_BOOT);
    in_session = (state_q == ST_RUN) || (state_q == ST_STEP);
    retire     = cpu_retire && in_session;
    clr_cnt    = cmd_fire && (op == OP_CLR_CNT);
    wdt_next   = wdt_q + 32'd1;
    stop_d     = SR_NONE;
    if (in_session) begin
      if (cmd_fire && (op == OP_HALT)) begin
        stop_d = SR_HOST;
      end else if (retire && cpu_halt_instr) begin
        stop_d = SR_HALT_INSTR;
      // first_q lets a RUN resume from the instruction it stopped on
      end else if ((state_q == ST_RUN) && retire && bp_en_q && !first_q &&
                   (cpu_pc == bp_addr_q)) begin
        stop_d = SR_BREAKPOINT;
      end else if ((WDT_LIMIT != 32'd0) && (wdt_next == WDT_LIMIT)) begin
        stop_d = SR_WATCHDOG;
      end else if ((state_q == ST_STEP) && retire) begin
        stop_d = SR_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= BOOT_RELOAD;
      stop_reason_q <= SR_NONE;
      stopped_q     <= 1'b0;
      bp_en_q       <= 1'b0;
      bp_addr_q     <= '0;
      wdt_q         <= '0;
      first_q       <= 1'b0;
    end else begin
      stopped_q <= 1'b0;
      if (in_session) wdt_q <= wdt_next;
      if (retire) first_q <= 1'b0;
      if (cmd_fire && (op == OP_SET_BP)) begin
        bp_addr_q <= cmd_data;
        bp_en_q   <= 1'b1;
      end
      if (cmd_fire && (op == OP_CLR_BP)) bp_en_q <= 1'b0;

      case (state_q)
        ST_BOOT: begin
          boot_cnt_q <= boot_cnt_q - 32'd1;
          if (boot_cnt_q <= 32'd1) begin
            if (AUTO_RUN != 0) begin
              state_q <= ST_RUN;
              wdt_q   <= '0;
              first_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (cmd_fire && (op == OP_RUN)) begin
            state_q       <= ST_RUN;
            stop_reason_q <= SR_NONE;
            wdt_q         <= '0;
            first_q       <= 1'b1;
          end else if (cmd_fire && (op == OP_STEP)) begin
            state_q       <= ST_STEP;
            stop_reason_q <= SR_NONE;
            wdt_q         <= '0;
          end else if (cmd_fire && (op == OP_CPU_RESET)) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= BOOT_RELOAD;
            stop_reason_q <= SR_NONE;
          end
        end
        default: begin
          if (cmd_fire && (op == OP_CPU_RESET)) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= BOOT_RELOAD;
            stop_reason_q <= SR_NONE;
          end else if (stop_d != SR_NONE) begin
            state_q       <= ST_IDLE;
            stop_reason_q <= stop_d;
            stopped_q     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign cmd_ready   = (state_q != ST_BOOT);
  assign cpu_reset   = (state_q == ST_BOOT);
  assign run_cpu     = in_session;
  assign ctrl_state  = state_q;
  assign stop_reason = stop_reason_q;
  assign stopped     = stopped_q;

  run_stat_counter u_cycle_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (in_session),
    .clr_i   (clr_cnt),
    .count_o (cycle_count)
  );

  run_stat_counter u_instr_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (retire),
    .clr_i   (clr_cnt),
    .count_o (instr_count)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: boot, halt-instruction, breakpoint resume,
// step, stop priority, watchdog, counter clear and CPU_RESET.
module tb_cpu_run_ctrl;
  import beta_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        cpu_retire;
  logic [31:0] cpu_pc;
  logic        cpu_halt_instr;
  logic        cpu_reset;
  logic        run_cpu;
  logic [1:0]  ctrl_state;
  logic [2:0]  stop_reason;
  logic        stopped;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  int total;
  int bad;
  int n;

  cpu_run_ctrl #(
    .RESET_CYCLES (4),
    .AUTO_RUN     (0),
    .WDT_CYCLES   (10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .cmd_ready      (cmd_ready),
    .cpu_retire     (cpu_retire),
    .cpu_pc         (cpu_pc),
    .cpu_halt_instr (cpu_halt_instr),
    .cpu_reset      (cpu_reset),
    .run_cpu        (run_cpu),
    .ctrl_state     (ctrl_state),
    .stop_reason    (stop_reason),
    .stopped        (stopped),
    .cycle_count    (cycle_count),
    .instr_count    (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 32'd0;
  endtask

  task automatic retire_at(input logic [31:0] pc, input logic halt);
    cpu_retire     = 1'b1;
    cpu_pc         = pc;
    cpu_halt_instr = halt;
    tick();
    cpu_retire     = 1'b0;
    cpu_halt_instr = 1'b0;
  endtask

  task automatic count_boot();
    n = 0;
    while (cpu_reset === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_data = 32'd0;
    cpu_retire = 1'b0;
    cpu_pc = 32'd0;
    cpu_halt_instr = 1'b0;

    // reset values
    tick();
    tick();
    chk("rst_state", 32'(ctrl_state), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_run", 32'(run_cpu), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_reason", 32'(stop_reason), 32'd0);
    chk("rst_stopped", 32'(stopped), 32'd0);
    chk("rst_cyc", cycle_count, 32'd0);
    chk("rst_instr", instr_count, 32'd0);

    // boot sequence
    reset = 1'b0;
    count_boot();
    chk("boot_len", 32'(n), 32'd4);
    chk("boot_idle", 32'(ctrl_state), 32'd1);
    chk("boot_ready", 32'(cmd_ready), 32'd1);
    chk("boot_run", 32'(run_cpu), 32'd0);

    // run until a HALT instruction retires
    send(OP_RUN, 32'd0);
    chk("run_state", 32'(ctrl_state), 32'd2);
    chk("run_run", 32'(run_cpu), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      retire_at(32'h100 + 32'(4 * i), (i == 5));
    end
    chk("hi_reason", 32'(stop_reason), 32'd2);
    chk("hi_stopped", 32'(stopped), 32'd1);
    chk("hi_run_low", 32'(run_cpu), 32'd0);
    chk("hi_state", 32'(ctrl_state), 32'd1);
    chk("hi_instr", instr_count, 32'd5);
    chk("hi_cyc", cycle_count, 32'd5);
    tick();
    chk("hi_pulse_end", 32'(stopped), 32'd0);

    // retire while idle is ignored; HALT in IDLE is a no-op
    retire_at(32'h300, 1'b0);
    chk("idle_retire", instr_count, 32'd5);
    send(OP_HALT, 32'd0);
    chk("idle_halt_state", 32'(ctrl_state), 32'd1);
    chk("idle_halt_reason", 32'(stop_reason), 32'd2);

    // breakpoint hit, then resume from it
    send(OP_SET_BP, 32'h40);
    send(OP_RUN, 32'd0);
    chk("bp_reason_clr", 32'(stop_reason), 32'd0);
    retire_at(32'h3C, 1'b0);
    chk("bp_pre", 32'(ctrl_state), 32'd2);
    retire_at(32'h40, 1'b0);
    chk("bp_reason", 32'(stop_reason), 32'd3);
    chk("bp_state", 32'(ctrl_state), 32'd1);
    chk("bp_instr", instr_count, 32'd7);
    send(OP_RUN, 32'd0);
    retire_at(32'h40, 1'b0);
    chk("bp_resume", 32'(ctrl_state), 32'd2);
    retire_at(32'h44, 1'b0);
    retire_at(32'h40, 1'b0);
    chk("bp_again", 32'(stop_reason), 32'd3);
    chk("bp_again_instr", instr_count, 32'd10);

    // single step: breakpoint not checked, then halt-instr beats step
    send(OP_STEP, 32'd0);
    chk("step_state", 32'(ctrl_state), 32'd3);
    chk("step_run", 32'(run_cpu), 32'd1);
    tick();
    chk("step_wait", 32'(ctrl_state), 32'd3);
    retire_at(32'h40, 1'b0);
    chk("step_reason", 32'(stop_reason), 32'd4);
    chk("step_stopped", 32'(stopped), 32'd1);
    chk("step_instr", instr_count, 32'd11);
    send(OP_STEP, 32'd0);
    retire_at(32'h50, 1'b1);
    chk("step_hi_reason", 32'(stop_reason), 32'd2);
    chk("step_hi_instr", instr_count, 32'd12);

    // RUN ignored while running; host HALT beats a breakpoint match
    send(OP_RUN, 32'd0);
    send(OP_RUN, 32'd0);
    chk("run_in_run", 32'(ctrl_state), 32'd2);
    retire_at(32'h44, 1'b0);
    cmd_valid = 1'b1;
    cmd_op = OP_HALT;
    cpu_retire = 1'b1;
    cpu_pc = 32'h40;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cpu_retire = 1'b0;
    chk("prio_reason", 32'(stop_reason), 32'd1);
    chk("prio_instr", instr_count, 32'd14);
    chk("prio_cyc", cycle_count, 32'd16);

    // counter clear wins over a same-cycle increment
    send(OP_RUN, 32'd0);
    cmd_valid = 1'b1;
    cmd_op = OP_CLR_CNT;
    cpu_retire = 1'b1;
    cpu_pc = 32'h200;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cpu_retire = 1'b0;
    chk("clr_cyc", cycle_count, 32'd0);
    chk("clr_instr", instr_count, 32'd0);
    chk("clr_state", 32'(ctrl_state), 32'd2);
    send(OP_HALT, 32'd0);
    chk("clr_after_cyc", cycle_count, 32'd1);
    chk("clr_after_reason", 32'(stop_reason), 32'd1);
    send(OP_CLR_CNT, 32'd0);
    chk("clr_idle_cyc", cycle_count, 32'd0);

    // watchdog
    send(OP_RUN, 32'd0);
    n = 0;
    while (run_cpu === 1'b1 && n < 30) begin
      n++;
      tick();
    end
    chk("wdt_len", 32'(n), 32'd10);
    chk("wdt_reason", 32'(stop_reason), 32'd5);
    chk("wdt_stopped", 32'(stopped), 32'd1);
    chk("wdt_cyc", cycle_count, 32'd10);
    chk("wdt_state", 32'(ctrl_state), 32'd1);

    // CPU_RESET during RUN keeps counters and breakpoint
    send(OP_RUN, 32'd0);
    retire_at(32'h100, 1'b0);
    send(OP_CPU_RESET, 32'd0);
    chk("cr_state", 32'(ctrl_state), 32'd0);
    chk("cr_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("cr_stopped", 32'(stopped), 32'd0);
    chk("cr_reason", 32'(stop_reason), 32'd0);
    chk("cr_ready", 32'(cmd_ready), 32'd0);
    count_boot();
    chk("cr_boot_len", 32'(n), 32'd4);
    chk("cr_idle", 32'(ctrl_state), 32'd1);
    chk("cr_cyc", cycle_count, 32'd12);
    chk("cr_instr", instr_count, 32'd1);
    send(OP_RUN, 32'd0);
    retire_at(32'h44, 1'b0);
    retire_at(32'h40, 1'b0);
    chk("cr_bp_kept", 32'(stop_reason), 32'd3);

    // synchronous reset mid-RUN with a command in flight
    send(OP_RUN, 32'd0);
    cmd_valid = 1'b1;
    cmd_op = OP_HALT;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    chk("sr_state", 32'(ctrl_state), 32'd0);
    chk("sr_reason", 32'(stop_reason), 32'd0);
    chk("sr_stopped", 32'(stopped), 32'd0);
    chk("sr_cyc", cycle_count, 32'd0);
    chk("sr_instr", instr_count, 32'd0);
    count_boot();
    chk("sr_boot_len", 32'(n), 32'd4);
    send(OP_RUN, 32'd0);
    retire_at(32'h44, 1'b0);
    retire_at(32'h40, 1'b0);
    chk("sr_bp_cleared", 32'(ctrl_state), 32'd2);
    send(OP_HALT, 32'd0);
    chk("sr_halt", 32'(stop_reason), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step/halt sequencer for the Beta CPU core.
- Owns the core's reset and runCPU enable; accepts host commands over a valid/ready port.
- Stops the core on HALT instruction, PC breakpoint, single-step completion or watchdog expiry.
- Keeps cycle and retired-instruction counters; sits between the debug/host interface and the CPU top.

Parameters:
- RESET_CYCLES, 4: cycles cpu_reset is held after reset or a CPU_RESET command (≥1).
- AUTO_RUN, 0: 1 = enter RUN automatically when BOOT completes.
- WDT_CYCLES, 0: maximum run_cpu-high cycles per RUN session; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_op  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CPU_RESET, 7 CLR_CNT
- cmd_data  in  32  breakpoint address for SET_BP
- cmd_ready  out  1  command accepted when valid&ready
- cpu_retire  in  1  CPU retired an instruction this cycle
- cpu_pc  in  32  PC of the retiring instruction
- cpu_halt_instr  in  1  retiring instruction is HALT
- cpu_reset  out  1  reset to CPU core
- run_cpu  out  1  CPU runCPU enable
- ctrl_state  out  2  0 BOOT, 1 IDLE, 2 RUN, 3 STEP
- stop_reason  out  3  0 NONE, 1 HOST, 2 HALT_INSTR, 3 BREAKPOINT, 4 STEP, 5 WATCHDOG
- stopped  out  1  one-cycle pulse on each RUN/STEP→IDLE transition
- cycle_count  out  32  cycles with run_cpu=1
- instr_count  out  32  retires with run_cpu=1

Behaviour:
- Reset values:
  - state = BOOT; boot counter = RESET_CYCLES; cpu_reset = 1; run_cpu = 0; cmd_ready = 0.
  - stop_reason = NONE; stopped = 0; counters = 0; bp_en = 0; bp_addr = 0.
- All outputs decode from registers; no combinational input→output paths.
- BOOT:
  - cpu_reset = 1; counter decrements each cycle.
  - On the cycle it reads 1, next state is RUN if AUTO_RUN, else IDLE.
  - cpu_reset is high for exactly RESET_CYCLES cycles.
- cmd_ready = (state != BOOT). Commands presented while not ready are neither accepted nor queued.
- IDLE: RUN → RUN state; STEP → STEP state; HALT is a no-op; stop_reason holds until the next RUN/STEP, which clears it to NONE.
- run_cpu = 1 exactly in RUN and STEP.
- Stop evaluation, in RUN/STEP, at any edge, priority high→low:
  - HOST: HALT command accepted.
  - HALT_INSTR: cpu_retire & cpu_halt_instr.
  - BREAKPOINT: cpu_retire & bp_en & cpu_pc == bp_addr, excluding the first retire of a RUN session, so resume from a breakpoint proceeds.
  - WATCHDOG: WDT_CYCLES ≠ 0 and the session cycle counter reaches WDT_CYCLES.
  - STEP: in STEP state, any cpu_retire.
- On a stop: next state IDLE, run_cpu low the following cycle, so no extra retire is sampled. stop_reason is loaded, and stopped pulses for 1 cycle.
- The breakpoint is not checked in STEP.
- RUN/STEP commands arriving while already in RUN/STEP are ignored.
- SET_BP: bp_addr = cmd_data, bp_en = 1. CLR_BP: bp_en = 0. Both are valid in any non-BOOT state and take effect on the next edge.
- CPU_RESET:
  - In any non-BOOT state, go to BOOT with the counter reloaded.
  - stop_reason = NONE, no stopped pulse.
  - Counters and breakpoint are retained.
- Counters:
  - Increment modulo 2^32 and wrap silently.
  - CLR_CNT zeroes both counters; a clear wins over a simultaneous increment.
  - The session watchdog counter resets on each entry to RUN.
- cpu_retire while run_cpu = 0 is ignored and not counted.
- Synchronous reset mid-RUN returns to BOOT with all reset values, regardless of any command in flight.

Decomposition:
- Package beta_ctrl_pkg holds the cmd_op encodings, the ctrl_state encodings, the stop_reason encodings and the 32-bit word width constant.
- One natural sub-module: run_stat_counter, a 32-bit counter with inc/clr and clear priority, instantiated twice for cycle_count and instr_count.

Test Plan:
- Boot: reset high 2 cycles, RESET_CYCLES = 4 → cpu_reset high exactly 4 cycles after reset release, then ctrl_state = IDLE, cmd_ready = 1, run_cpu = 0.
- Run/halt-instruction: RUN, then 5 retires with the 5th carrying cpu_halt_instr → stop_reason = 2, stopped 1-cycle pulse, instr_count = 5, run_cpu low the next cycle.
- Breakpoint resume:
  - SET_BP 0x40, RUN, retire at PC 0x3C then 0x40 → stop_reason = 3.
  - RUN again, first retire at 0x40 → no stop; a later retire at 0x40 → stop_reason = 3.
- Step and priority:
  - STEP with one retire → stop_reason = 4, instr_count + 1.
  - STEP where that retire has cpu_halt_instr → stop_reason = 2.
  - In RUN, HALT command in the same cycle as a bp-match retire → stop_reason = 1.
- Watchdog: WDT_CYCLES = 10, RUN with no retires → run_cpu high exactly 10 cycles, stop_reason = 5, cycle_count = 10.
- Clear/reset edges:
  - CLR_CNT in a cycle with an increment → both counters read 0 the next cycle.
  - CPU_RESET during RUN → BOOT, cpu_reset high 4 cycles, breakpoint still armed, counters retained.
